// File: rtl/fpga_system_pio_in_edge.sv
// Avalon-MM input PIO with synchroniser, optional debounce, per-bit edge
// capture (write-1-to-clear) and a maskable level interrupt.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   address[1:0]            register word address (0 DATA, 1 EDGE_MODE, 2 IRQ_MASK, 3 EDGECAPTURE)
//   chipselect, write_n     write qualifier (write when chipselect=1 and write_n=0)
//   writedata[31:0]         write data
//   in_port[WIDTH-1:0]      asynchronous board inputs
//   readdata[31:0]          registered read data, refreshed every clock
//   irq                     registered level interrupt, active high
module fpga_system_pio_in_edge #(
    parameter int unsigned WIDTH           = 18,
    parameter int unsigned DEBOUNCE_CYCLES = 0,
    parameter int unsigned EDGE_MODE_RESET = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_next;
    logic [1:0]       edge_mode;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] capture;
    logic [WIDTH-1:0] clear_mask;
    logic [WIDTH-1:0] mask_next;
    logic [WIDTH-1:0] edgecap_next;
    logic [31:0]      read_mux;
    logic             wr;
    logic             unused_wdata;

    // Upper writedata bits are don't-care for narrow configurations.
    assign unused_wdata = ^writedata;

    // Two-flop synchroniser.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
            // Stable is the synchroniser output itself; its next value is sync1.
            assign stable      = sync2;
            assign stable_next = sync1;
        end else begin : g_debounce
            for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
                logic [CNT_W-1:0] cnt;
                logic             stable_q;
                logic             accept;

                // Accept on the edge where the disagreement has lasted DEBOUNCE_CYCLES clocks.
                assign accept         = (sync2[i] != stable_q) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
                assign stable_next[i] = accept ? sync2[i] : stable_q;
                assign stable[i]      = stable_q;

                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        cnt      <= '0;
                        stable_q <= 1'b0;
                    end else begin
                        stable_q <= stable_next[i];
                        if ((sync2[i] == stable_q) || accept) begin
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
            end
        end
    endgenerate

    assign rise = stable_next & ~stable;
    assign fall = ~stable_next & stable;
    assign wr   = chipselect & ~write_n;

    // Capture selection uses the mode in force before this edge.
    always_comb begin
        capture = '0;
        case (edge_mode)
            2'd0:    capture = rise;
            2'd1:    capture = fall;
            2'd2:    capture = rise | fall;
            default: capture = '0;
        endcase
    end

    // Next-state of the software-visible registers; a capture beats a same-edge clear.
    always_comb begin
        clear_mask   = (wr && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;
        mask_next    = (wr && (address == 2'd2)) ? writedata[WIDTH-1:0] : irq_mask;
        edgecap_next = (edgecap & ~clear_mask) | capture;
    end

    // Read mux over current register contents.
    always_comb begin
        read_mux = '0;
        case (address)
            2'd0:    read_mux = 32'(stable);
            2'd1:    read_mux = 32'(edge_mode);
            2'd2:    read_mux = 32'(irq_mask);
            default: read_mux = 32'(edgecap);
        endcase
    end

    // Register file, read data and interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_mode <= 2'(EDGE_MODE_RESET);
            irq_mask  <= '0;
            edgecap   <= '0;
            irq       <= 1'b0;
            readdata  <= '0;
        end else begin
            if (wr && (address == 2'd1)) begin
                edge_mode <= writedata[1:0];
            end
            irq_mask <= mask_next;
            edgecap  <= edgecap_next;
            irq      <= |(edgecap_next & mask_next);
            readdata <= read_mux;
        end
    end

endmodule

// File: tb/tb_fpga_system_pio_in_edge.sv
// Directed bench for fpga_system_pio_in_edge across four configurations:
// u0 (WIDTH=18, no debounce), u1 (WIDTH=18, DEBOUNCE_CYCLES=4, EDGE_MODE_RESET=2),
// u2 (WIDTH=32) and u3 (WIDTH=8). The address/write bus is shared; chipselect is per instance.
module tb_fpga_system_pio_in_edge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  cs;

    logic [17:0] in0;
    logic [17:0] in1;
    logic [31:0] in2;
    logic [7:0]  in3;
    logic [31:0] rd0, rd1, rd2, rd3;
    logic        irq0, irq1, irq2, irq3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fpga_system_pio_in_edge #(.WIDTH(18), .DEBOUNCE_CYCLES(0), .EDGE_MODE_RESET(0)) u0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[0]), .write_n(write_n),
        .writedata(writedata), .in_port(in0), .readdata(rd0), .irq(irq0));

    fpga_system_pio_in_edge #(.WIDTH(18), .DEBOUNCE_CYCLES(4), .EDGE_MODE_RESET(2)) u1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[1]), .write_n(write_n),
        .writedata(writedata), .in_port(in1), .readdata(rd1), .irq(irq1));

    fpga_system_pio_in_edge #(.WIDTH(32), .DEBOUNCE_CYCLES(0), .EDGE_MODE_RESET(0)) u2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[2]), .write_n(write_n),
        .writedata(writedata), .in_port(in2), .readdata(rd2), .irq(irq2));

    fpga_system_pio_in_edge #(.WIDTH(8), .DEBOUNCE_CYCLES(0), .EDGE_MODE_RESET(0)) u3 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[3]), .write_n(write_n),
        .writedata(writedata), .in_port(in3), .readdata(rd3), .irq(irq3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int inst, input logic [1:0] addr, input logic [31:0] data);
        address   = addr;
        writedata = data;
        write_n   = 1'b0;
        cs        = 4'(1 << inst);
        tick();
        cs        = '0;
        write_n   = 1'b1;
    endtask

    task automatic rd(input int inst, input logic [1:0] addr, output logic [31:0] data);
        address = addr;
        tick();
        case (inst)
            0:       data = rd0;
            1:       data = rd1;
            2:       data = rd2;
            default: data = rd3;
        endcase
    endtask

    initial begin
        logic [31:0] v;
        reset_n   = 1'b0;
        address   = '0;
        write_n   = 1'b1;
        writedata = '0;
        cs        = '0;
        in0       = '1;
        in1       = '1;
        in2       = '1;
        in3       = '1;

        // Reset holds everything at zero even with inputs high.
        repeat (3) tick();
        chk("reset_readdata_u0", rd0, 32'h0);
        chk("reset_irq_u0", 32'(irq0), 32'h0);
        chk("reset_readdata_u1", rd1, 32'h0);
        chk("reset_irq_u1", 32'(irq1), 32'h0);

        in0 = '0; in1 = '0; in2 = '0; in3 = '0;
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        rd(0, 2'd1, v); chk("edge_mode_reset_u0", v, 32'h0);
        rd(1, 2'd1, v); chk("edge_mode_reset_u1", v, 32'h2);

        // u0: rising capture and irq timing, then W1C.
        wr(0, 2'd2, 32'h1);
        in0 = 18'h00001;
        tick();
        chk("u0_irq_after_E0", 32'(irq0), 32'h0);
        tick();
        chk("u0_irq_after_E1", 32'(irq0), 32'h1);
        rd(0, 2'd0, v); chk("u0_data", v, 32'h00001);
        rd(0, 2'd3, v); chk("u0_edgecap_rise", v, 32'h1);
        wr(0, 2'd3, 32'h1);
        chk("u0_irq_after_w1c", 32'(irq0), 32'h0);
        rd(0, 2'd3, v); chk("u0_edgecap_cleared", v, 32'h0);

        // Falling mode: only the high-to-low transition of bit 2 is captured.
        wr(0, 2'd1, 32'h1);
        in0 = 18'h00005; repeat (3) tick();
        in0 = 18'h00001; repeat (3) tick();
        rd(0, 2'd3, v); chk("u0_fall_mode", v, 32'h4);
        chk("u0_irq_unmasked_bit", 32'(irq0), 32'h0);
        wr(0, 2'd3, 32'h4);

        // Capture disabled.
        wr(0, 2'd1, 32'h3);
        in0 = 18'h00005; repeat (3) tick();
        in0 = 18'h00001; repeat (3) tick();
        rd(0, 2'd3, v); chk("u0_mode_disabled", v, 32'h0);

        // Any-edge mode: both transitions capture.
        wr(0, 2'd1, 32'h2);
        in0 = 18'h00005; repeat (3) tick();
        rd(0, 2'd3, v); chk("u0_any_rise", v, 32'h4);
        wr(0, 2'd3, 32'h4);
        in0 = 18'h00001; repeat (3) tick();
        rd(0, 2'd3, v); chk("u0_any_fall", v, 32'h4);
        wr(0, 2'd3, 32'h4);

        // Same-edge W1C and new capture on bit 3: capture wins.
        wr(0, 2'd2, 32'h8);
        in0 = 18'h00009; repeat (3) tick();
        chk("u0_bit3_irq_set", 32'(irq0), 32'h1);
        in0 = 18'h00001;
        tick();
        wr(0, 2'd3, 32'h8);
        chk("u0_collide_irq", 32'(irq0), 32'h1);
        rd(0, 2'd3, v); chk("u0_collide_edgecap", v, 32'h8);

        // u1: a 3-cycle glitch never reaches stable.
        wr(1, 2'd2, 32'h20);
        in1 = 18'h00020; repeat (3) tick();
        in1 = 18'h00000; repeat (6) tick();
        chk("u1_glitch_irq", 32'(irq1), 32'h0);
        rd(1, 2'd0, v); chk("u1_glitch_data", v, 32'h0);
        rd(1, 2'd3, v); chk("u1_glitch_edgecap", v, 32'h0);

        // u1: a held input is accepted exactly at E5.
        address = 2'd0;
        in1 = 18'h00020;
        tick();
        repeat (4) tick();
        chk("u1_irq_after_E4", 32'(irq1), 32'h0);
        tick();
        chk("u1_irq_after_E5", 32'(irq1), 32'h1);
        tick();
        chk("u1_data_after_E6", rd1, 32'h20);
        rd(1, 2'd3, v); chk("u1_edgecap", v, 32'h20);

        // Width boundaries.
        in2 = 32'hFFFF_FFFF; repeat (3) tick();
        rd(2, 2'd0, v); chk("u2_data_w32", v, 32'hFFFF_FFFF);
        wr(3, 2'd2, 32'hFFFF_FFFF);
        rd(3, 2'd2, v); chk("u3_mask_w8", v, 32'h0000_00FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
